// File: rtl/scarv_cop_ibuffer.sv
// scarv_cop_ibuffer: in-order instruction FIFO between the host CPU req/ack port and the coprocessor decoder
module scarv_cop_ibuffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             cpu_insn_req,
  output logic             cop_insn_ack,
  input  logic [31:0]      cpu_insn_enc,
  input  logic [31:0]      cpu_rs1,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_encoded,
  output logic [31:0]      id_rs1_val,
  output logic [PTR_W:0]   id_tag,
  input  logic             flush,
  output logic [PTR_W:0]   buf_count
);
  logic [31:0]      enc_mem [DEPTH];
  logic [31:0]      rs1_mem [DEPTH];
  logic [PTR_W:0]   tag_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d, tag_q, tag_d;
  logic             push, pop;
  always_comb begin
    cop_insn_ack = (count_q != (PTR_W+1)'(DEPTH)) && !flush;
    id_valid     = count_q != '0;
    push         = cpu_insn_req && cop_insn_ack;
    pop          = id_valid && id_ready;
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = flush ? wr_ptr_q : rd_ptr_q + PTR_W'(pop);
    count_d      = flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    tag_d        = tag_q + (PTR_W+1)'(push);
    id_encoded   = id_valid ? enc_mem[rd_ptr_q] : '0;
    id_rs1_val   = id_valid ? rs1_mem[rd_ptr_q] : '0;
    id_tag       = id_valid ? tag_mem[rd_ptr_q] : '0;
    buf_count    = count_q;
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      tag_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      tag_q    <= tag_d;
    end
  end
  // Entry storage is left unreset; the head outputs are masked while empty.
  always_ff @(posedge g_clk) begin
    if (push) begin
      enc_mem[wr_ptr_q] <= cpu_insn_enc;
      rs1_mem[wr_ptr_q] <= cpu_rs1;
      tag_mem[wr_ptr_q] <= tag_q;
    end
  end
endmodule

// File: tb/tb_scarv_cop_ibuffer.sv
// tb_scarv_cop_ibuffer: scoreboard bench for the coprocessor instruction buffer
module tb_scarv_cop_ibuffer;
  logic        g_clk, g_resetn, cpu_insn_req, cop_insn_ack, id_valid, id_ready, flush;
  logic [31:0] cpu_insn_enc, cpu_rs1, id_encoded, id_rs1_val;
  logic [2:0]  id_tag, buf_count;
  typedef struct packed {
    logic [31:0] enc;
    logic [31:0] rs1;
    logic [2:0]  tag;
  } ent_t;
  ent_t        sb[$];
  logic [2:0]  m_tag;
  int          n_checks, n_fail;

  scarv_cop_ibuffer #(.DEPTH(4), .PTR_W(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .id_valid(id_valid), .id_ready(id_ready),
    .id_encoded(id_encoded), .id_rs1_val(id_rs1_val), .id_tag(id_tag), .flush(flush),
    .buf_count(buf_count)
  );

  initial g_clk = 0;
  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end, required completion");
    $fatal(1, "timeout");
  end

  // Advance one clock and update the reference queue with what the buffer should have done.
  task automatic tick();
    bit do_push, do_pop;
    do_push = g_resetn && cpu_insn_req && !flush && sb.size() < 4;
    do_pop  = g_resetn && !flush && id_ready && sb.size() > 0;
    @(posedge g_clk);
    if (!g_resetn) begin
      sb.delete();
      m_tag = '0;
    end else if (flush) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back('{enc: cpu_insn_enc, rs1: cpu_rs1, tag: m_tag});
        m_tag = m_tag + 3'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    g_resetn = 0; cpu_insn_req = 0; id_ready = 0; flush = 0; cpu_insn_enc = '0; cpu_rs1 = '0;
    tick(); tick();
    g_resetn = 1; #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_checks++; if (cop_insn_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b expected 1", cop_insn_ack); end
    n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", buf_count); end
    n_checks++; if (id_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", id_tag); end
    n_checks++; if (id_encoded !== 32'h0) begin n_fail++; $display("FAIL reset_enc: got %h expected 0", id_encoded); end
    n_checks++; if (id_rs1_val !== 32'h0) begin n_fail++; $display("FAIL reset_rs1: got %h expected 0", id_rs1_val); end
  endtask

  task automatic test_single();
    cpu_insn_req = 1; cpu_insn_enc = 32'h0000_302B; cpu_rs1 = 32'hDEAD_BEEF; id_ready = 0; #1;
    n_checks++; if (cop_insn_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b expected 1", cop_insn_ack); end
    tick();
    cpu_insn_req = 0; #1;
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", id_valid); end
    n_checks++; if (id_encoded !== 32'h0000_302B) begin n_fail++; $display("FAIL single_enc: got %h expected 0000302b", id_encoded); end
    n_checks++; if (id_rs1_val !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rs1: got %h expected deadbeef", id_rs1_val); end
    n_checks++; if (id_tag !== 3'd0) begin n_fail++; $display("FAIL single_tag: got %0d expected 0", id_tag); end
    n_checks++; if (buf_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", buf_count); end
    id_ready = 1; tick(); id_ready = 0; #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: valid got %b expected 0", id_valid); end
  endtask

  task automatic test_fill_drain();
    id_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      cpu_insn_req = 1; cpu_insn_enc = 32'h10 + i; cpu_rs1 = $urandom; #1;
      n_checks++; if (cop_insn_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack%0d: got %b expected 1", i, cop_insn_ack); end
      tick();
    end
    cpu_insn_enc = 32'h15; #1;
    n_checks++; if (cop_insn_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack: got %b expected 0", cop_insn_ack); end
    n_checks++; if (buf_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", buf_count); end
    cpu_insn_req = 0; id_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid%0d: got %b expected 1", i, id_valid); end
      n_checks++; if (id_encoded !== 32'h11 + i || id_encoded !== sb[0].enc) begin n_fail++; $display("FAIL drain_enc%0d: got %h expected %h", i, id_encoded, 32'h11 + i); end
      n_checks++; if (id_rs1_val !== sb[0].rs1) begin n_fail++; $display("FAIL drain_rs1%0d: got %h expected %h", i, id_rs1_val, sb[0].rs1); end
      n_checks++; if (cop_insn_ack !== (i != 0)) begin n_fail++; $display("FAIL drain_ack%0d: got %b expected %b", i, cop_insn_ack, i != 0); end
      tick();
    end
    id_ready = 0; #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: valid got %b expected 0", id_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      cpu_insn_req = 1; id_ready = 1; cpu_insn_enc = $urandom; cpu_rs1 = $urandom; #1;
      n_checks++; if (cop_insn_ack !== 1'b1) begin n_fail++; $display("FAIL stream_ack%0d: got %b expected 1", i, cop_insn_ack); end
      n_checks++; if (buf_count !== 3'(sb.size())) begin n_fail++; $display("FAIL stream_count%0d: got %0d expected %0d", i, buf_count, sb.size()); end
      if (sb.size() > 0) begin
        n_checks++; if ({id_valid, id_encoded, id_rs1_val, id_tag} !== {1'b1, sb[0]}) begin n_fail++; $display("FAIL stream_head%0d: got %b %h %h %0d expected 1 %h %h %0d", i, id_valid, id_encoded, id_rs1_val, id_tag, sb[0].enc, sb[0].rs1, sb[0].tag); end
      end
      tick();
    end
    cpu_insn_req = 0; #1;
    n_checks++; if (buf_count !== 3'd1) begin n_fail++; $display("FAIL stream_steady: got %0d expected 1", buf_count); end
    n_checks++; if (id_tag !== 3'(sb[0].tag)) begin n_fail++; $display("FAIL stream_lasttag: got %0d expected %0d", id_tag, sb[0].tag); end
    tick(); id_ready = 0; #1;
  endtask

  task automatic test_flush();
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_insn_req = 1; cpu_insn_enc = 32'hA0 + i; cpu_rs1 = $urandom; tick();
    end
    cpu_insn_enc = 32'hF1; cpu_rs1 = 32'h1234_5678; flush = 1; #1;
    n_checks++; if (cop_insn_ack !== 1'b0) begin n_fail++; $display("FAIL flush_ack: got %b expected 0", cop_insn_ack); end
    tick();
    flush = 0; #1;
    n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", buf_count); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_encoded !== 32'h0) begin n_fail++; $display("FAIL flush_enc: got %h expected 0", id_encoded); end
    n_checks++; if (cop_insn_ack !== 1'b1) begin n_fail++; $display("FAIL flush_reack: got %b expected 1", cop_insn_ack); end
    tick();
    cpu_insn_req = 0; #1;
    n_checks++; if ({id_valid, id_encoded, id_rs1_val, id_tag} !== {1'b1, sb[0]}) begin n_fail++; $display("FAIL flush_held: got %b %h %h %0d expected 1 %h %h %0d", id_valid, id_encoded, id_rs1_val, id_tag, sb[0].enc, sb[0].rs1, sb[0].tag); end
    id_ready = 1; tick(); id_ready = 0; #1;
  endtask

  task automatic test_reset_mid();
    id_ready = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_insn_req = 1; cpu_insn_enc = 32'hC0 + i; cpu_rs1 = $urandom; tick();
    end
    g_resetn = 0; id_ready = 1; cpu_insn_enc = 32'hC9; tick();
    g_resetn = 1; cpu_insn_req = 0; id_ready = 0; #1;
    n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", buf_count); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_tag !== 3'd0) begin n_fail++; $display("FAIL rmid_tag: got %0d expected 0", id_tag); end
    n_checks++; if (cop_insn_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_ack: got %b expected 1", cop_insn_ack); end
  endtask

  task automatic test_empty_ready();
    id_ready = 1; cpu_insn_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({id_valid, buf_count} !== 4'b0) begin n_fail++; $display("FAIL empty_idle%0d: got valid %b count %0d expected 0 0", i, id_valid, buf_count); end
    end
    id_ready = 0; cpu_insn_req = 1; cpu_insn_enc = 32'hAB; cpu_rs1 = 32'h0BAD_F00D; tick();
    cpu_insn_req = 0; #1;
    n_checks++; if ({id_valid, id_encoded, id_rs1_val, id_tag} !== {1'b1, sb[0]} || id_tag !== 3'd0) begin n_fail++; $display("FAIL empty_push: got %b %h %h %0d expected 1 %h %h %0d", id_valid, id_encoded, id_rs1_val, id_tag, sb[0].enc, sb[0].rs1, sb[0].tag); end
    id_ready = 1; tick(); id_ready = 0; #1;
    n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL empty_final: got %0d expected 0", buf_count); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_tag = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_flush();
    test_reset_mid();
    test_empty_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scarv_cop_ibuffer.md
Name: scarv_cop_ibuffer

Overview:
Instruction input buffer that sits directly upstream of the coprocessor instruction decoder. It accepts instruction encodings and the accompanying GPR rs1 value from the host CPU over a req/ack handshake. It holds them in a small in-order FIFO and presents the oldest entry to the decode/dispatch stage over a valid/ready handshake. It also supports a pipeline flush and exposes occupancy for stall logic.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16.
PTR_W, 2, pointer width = log2(DEPTH); must be consistent with DEPTH.

Ports:
g_clk  input  1  single clock; all state updates on rising edge.
g_resetn  input  1  synchronous reset, active-low.
cpu_insn_req  input  1  host presents an instruction this cycle.
cop_insn_ack  output  1  buffer accepts the presented instruction this cycle.
cpu_insn_enc  input  32  instruction encoding.
cpu_rs1  input  32  value of the host GPR named by the rs1 field.
id_valid  output  1  head entry is valid for the decoder.
id_ready  input  1  decoder/dispatch consumes the head entry this cycle.
id_encoded  output  32  head entry encoding, driven straight into the decoder.
id_rs1_val  output  32  head entry rs1 value.
id_tag  output  PTR_W+1  sequence tag of the head entry.
flush  input  1  discard all buffered entries.
buf_count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is synchronous: when g_resetn=0 at a rising edge, the following are cleared:
  - rd_ptr=0, wr_ptr=0, count=0, tag counter=0.
  - Entry storage is not required to be reset.
- Outputs after reset: id_valid=0, cop_insn_ack=1 (if flush=0), buf_count=0, id_tag=0, id_encoded=0, id_rs1_val=0.
- id_encoded and id_rs1_val are masked to 0 whenever id_valid=0, so the decoder sees 0x00000000.
- Handshake and ack:
  - push = cpu_insn_req && cop_insn_ack.
  - pop = id_valid && id_ready.
  - cop_insn_ack = (count != DEPTH) && !flush. It is combinational from registered count and flush only, with no dependence on id_ready or cpu_insn_req.
  - The host holds cpu_insn_req, cpu_insn_enc and cpu_rs1 stable until it sees ack.
- Latency: an entry pushed in cycle N is visible with id_valid=1 in cycle N+1 at the earliest. There is no same-cycle bypass.
- id_valid = (count != 0). All head outputs are read from storage[rd_ptr].
- Push: write {enc, rs1, tag} into storage[wr_ptr]; wr_ptr wraps modulo DEPTH; the tag counter increments, wrapping modulo 2^(PTR_W+1).
- Pop: rd_ptr increments, wrapping modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged (legal whenever 0<count<DEPTH).
- Full (count=DEPTH): ack=0. A pop in the same cycle frees a slot from the next cycle onward; no same-cycle refill.
- Empty (count=0): id_valid=0. id_ready is ignored and no pop occurs.
- Flush:
  - Takes priority over push and pop: next cycle rd_ptr=wr_ptr, count=0.
  - Because ack=0 during flush, no instruction is lost.
  - The tag counter is not reset by flush.
- Reset mid-operation: overrides flush, push and pop; buffered entries are discarded.
- buf_count = count (registered).
- Entries leave strictly in acceptance order. The buffer never reorders, duplicates or drops an acked entry except on flush or reset.

Test Plan:
- Reset then single push of enc=0x0000_302B, rs1=0xDEAD_BEEF with id_ready=0 -> ack=1 in the push cycle. Next cycle: id_valid=1, id_encoded=0x0000_302B, id_rs1_val=0xDEAD_BEEF, id_tag=0, buf_count=1.
- Fill to DEPTH=4 with id_ready=0 using encodings 0x11..0x14 -> ack=0 once buf_count=4. Then assert id_ready for 4 cycles -> heads pop in order 0x11,0x12,0x13,0x14; id_valid drops after the fourth pop; ack returns the cycle after the first pop.
- Continuous req with id_ready=1 for 20 cycles -> steady state: one push and one pop per cycle, buf_count stays 1. Pointers and tag wrap (tag sequence 0..7,0..); order is preserved.
- Three entries buffered, flush=1 while cpu_insn_req=1 -> ack=0 in the flush cycle. Next cycle: buf_count=0, id_valid=0, id_encoded=0. The held request is accepted on the first non-flush cycle with the next tag value.
- Two entries buffered, g_resetn=0 for one cycle concurrent with req and id_ready -> next cycle: buf_count=0, id_valid=0, id_tag=0, ack=1; no pop or push takes effect.
- Empty buffer with id_ready=1 held high -> id_valid stays 0, buf_count stays 0, and no pointer change occurs (checked by a subsequent push appearing as id_tag=0).
